// File: rtl/even_leds_pkg.sv
// Shared types and constants for the even_leds LED driver.
// Build option: define EVEN_LEDS_PWM_EN to compile in PWM dimming of the LED drive.
package even_leds_pkg;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;

    localparam int STEP_CNT_W = 16;
    localparam int PWM_W      = 8;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // A programmed period of zero behaves like one cycle per step.
    function automatic logic [31:0] period_limit(input logic [31:0] period);
        return (period == 32'd0) ? 32'd1 : period;
    endfunction

endpackage

// File: rtl/even_leds_prescaler.sv
// Animation step timer: counts clock cycles and pulses o_tick once per programmed period.
// Held at zero while disabled; i_clr restarts the period and suppresses that cycle's tick.
module even_leds_prescaler
    import even_leds_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [31:0] i_period,
    output logic        o_tick
);

    logic [31:0] r_count;
    logic        w_last;

    assign w_last = (r_count == (period_limit(i_period) - 32'd1));
    assign o_tick = i_en & ~i_clr & w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 32'd0;
        end else if (i_clr || !i_en || w_last) begin
            r_count <= 32'd0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/even_leds_driver.sv
// Turns the even_leds register file into a registered, animated LED drive with a step counter.
// Build option: EVEN_LEDS_PWM_EN adds an 8-bit PWM dimmer controlled by duty_reg[7:0].
module even_leds_driver
    import even_leds_pkg::*;
#(
    parameter int                    NUM_LEDS = 8,
    parameter logic [NUM_LEDS-1:0]   LED_MASK = NUM_LEDS'(32'h5555_5555)
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [31:0]           ctrl_reg,
    input  logic [31:0]           pattern_reg,
    input  logic [31:0]           period_reg,
    input  logic [31:0]           duty_reg,
    input  logic                  cfg_wr,
    output logic [NUM_LEDS-1:0]   leds,
    output logic [STEP_CNT_W-1:0] step_cnt
);

    logic                  w_enable;
    mode_e                 w_mode;
    logic                  w_tick;
    logic                  w_pwm_on;
    logic                  w_blank;
    logic [NUM_LEDS-1:0]   w_disp;
    logic                  w_unused;

    logic [NUM_LEDS-1:0]   r_work;
    dir_e                  r_dir;
    logic                  r_phase;
    logic [STEP_CNT_W-1:0] r_step;
    logic [NUM_LEDS-1:0]   r_leds;

    assign w_enable = ctrl_reg[CTRL_EN_BIT];
    assign w_mode   = mode_e'(ctrl_reg[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    assign w_unused = ^{ctrl_reg, pattern_reg, duty_reg};

    even_leds_prescaler u_prescaler (
        .i_clk    (ACLK),
        .i_rst_n  (ARESETN),
        .i_clr    (cfg_wr),
        .i_en     (w_enable),
        .i_period (period_reg),
        .o_tick   (w_tick)
    );

    // The prescaler already drops the tick on a cfg_wr cycle, so reload always wins.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_work  <= '0;
            r_dir   <= DIR_LEFT;
            r_phase <= 1'b0;
            r_step  <= '0;
        end else if (cfg_wr) begin
            r_work  <= pattern_reg[NUM_LEDS-1:0];
            r_dir   <= DIR_LEFT;
            r_phase <= 1'b0;
            r_step  <= '0;
        end else if (w_tick) begin
            r_step <= r_step + 1'b1;
            case (w_mode)
                MODE_STATIC: r_work <= r_work;
                MODE_BLINK:  r_phase <= ~r_phase;
                MODE_ROTATE: r_work <= {r_work[NUM_LEDS-2:0], r_work[NUM_LEDS-1]};
                MODE_BOUNCE: begin
                    if (r_dir == DIR_LEFT) begin
                        if (r_work[NUM_LEDS-1]) begin
                            r_dir  <= DIR_RIGHT;
                            r_work <= r_work >> 1;
                        end else begin
                            r_work <= r_work << 1;
                        end
                    end else begin
                        if (r_work[0]) begin
                            r_dir  <= DIR_LEFT;
                            r_work <= r_work << 1;
                        end else begin
                            r_work <= r_work >> 1;
                        end
                    end
                end
                default: r_work <= r_work;
            endcase
        end
    end

`ifdef EVEN_LEDS_PWM_EN
    logic [PWM_W-1:0] r_pwm_cnt;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign w_pwm_on = (r_pwm_cnt < duty_reg[PWM_W-1:0]) | (duty_reg[PWM_W-1:0] == '1);
`else
    assign w_pwm_on = 1'b1;
`endif

    assign w_blank = ~w_enable | ((w_mode == MODE_BLINK) & r_phase);

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_disp
        assign w_disp[gi] = r_work[gi] & LED_MASK[gi] & w_pwm_on & ~w_blank;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_disp;
        end
    end

    assign leds     = r_leds;
    assign step_cnt = r_step;

endmodule

// File: tb/tb_even_leds_driver.sv
// Directed self-checking bench for even_leds_driver; inputs driven and outputs sampled on the falling edge.
// The PWM section runs only when EVEN_LEDS_PWM_EN is defined.
module tb_even_leds_driver;

    logic        ACLK;
    logic        ARESETN;
    logic [31:0] ctrl_reg;
    logic [31:0] pattern_reg;
    logic [31:0] period_reg;
    logic [31:0] duty_reg;
    logic        cfg_wr;
    logic [7:0]  leds;
    logic [15:0] step_cnt;

    int n_checks = 0;
    int n_errors = 0;

    even_leds_driver dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .ctrl_reg    (ctrl_reg),
        .pattern_reg (pattern_reg),
        .period_reg  (period_reg),
        .duty_reg    (duty_reg),
        .cfg_wr      (cfg_wr),
        .leds        (leds),
        .step_cnt    (step_cnt)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // Called on a falling edge; the reload edge is the next rising edge.
    task automatic pulse_cfg(input logic [31:0] ctrl, input logic [31:0] pat, input logic [31:0] per);
        ctrl_reg    = ctrl;
        pattern_reg = pat;
        period_reg  = per;
        cfg_wr      = 1'b1;
        @(negedge ACLK);
        cfg_wr      = 1'b0;
    endtask

`ifdef EVEN_LEDS_PWM_EN
    task automatic pwm_count(output int on_cnt, output int bad_cnt);
        on_cnt  = 0;
        bad_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge ACLK);
            if (leds == 8'h55)      on_cnt++;
            else if (leds != 8'h00) bad_cnt++;
        end
    endtask
`endif

    logic [7:0] bounce_exp [11];

    initial begin
        int on_cnt;
        int bad_cnt;
        bounce_exp = '{8'h40, 8'h00, 8'h40, 8'h00, 8'h10, 8'h00,
                       8'h04, 8'h00, 8'h01, 8'h00, 8'h04};

        ARESETN     = 1'b0;
        ctrl_reg    = 32'h7;
        pattern_reg = 32'hFF;
        period_reg  = 32'd1;
        duty_reg    = 32'hFF;
        cfg_wr      = 1'b0;

        // Reset held with nonzero registers
        wait_cyc(3);
        check_eq("reset_leds", 32'(leds), 32'h0);
        check_eq("reset_step", 32'(step_cnt), 32'h0);
        cfg_wr = 1'b1;
        wait_cyc(2);
        cfg_wr = 1'b0;
        check_eq("reset_leds_cfg", 32'(leds), 32'h0);

        ctrl_reg = 32'h0;
        ARESETN  = 1'b1;
        wait_cyc(5);
        check_eq("disabled_leds", 32'(leds), 32'h0);
        check_eq("disabled_step", 32'(step_cnt), 32'h0);

        // Static, period 3
        pulse_cfg(32'h1, 32'hFF, 32'd3);
        check_eq("static_latency", 32'(leds), 32'h0);
        wait_cyc(1);
        check_eq("static_leds", 32'(leds), 32'h55);
        check_eq("static_step_n1", 32'(step_cnt), 32'd0);
        wait_cyc(1);
        check_eq("static_step_n2", 32'(step_cnt), 32'd0);
        wait_cyc(1);
        check_eq("static_step_n3", 32'(step_cnt), 32'd1);
        wait_cyc(3);
        check_eq("static_step_n6", 32'(step_cnt), 32'd2);
        check_eq("static_leds_hold", 32'(leds), 32'h55);

        // Period 0 behaves as 1
        pulse_cfg(32'h1, 32'hFF, 32'd0);
        wait_cyc(3);
        check_eq("period0_step", 32'(step_cnt), 32'd3);

        // Rotate, period 4
        pulse_cfg(32'h5, 32'h01, 32'd4);
        wait_cyc(1);
        check_eq("rot_n1_leds", 32'(leds), 32'h01);
        check_eq("rot_n1_step", 32'(step_cnt), 32'd0);
        wait_cyc(3);
        check_eq("rot_n4_leds", 32'(leds), 32'h01);
        check_eq("rot_n4_step", 32'(step_cnt), 32'd1);
        wait_cyc(1);
        check_eq("rot_n5_leds", 32'(leds), 32'h00);
        wait_cyc(4);
        check_eq("rot_n9_leds", 32'(leds), 32'h04);
        check_eq("rot_n9_step", 32'(step_cnt), 32'd2);
        wait_cyc(8);
        check_eq("rot_n17_leds", 32'(leds), 32'h10);
        wait_cyc(16);
        check_eq("rot_wrap_leds", 32'(leds), 32'h01);
        check_eq("rot_wrap_step", 32'(step_cnt), 32'd8);

        // Bounce, period 1
        pulse_cfg(32'h7, 32'h40, 32'd1);
        for (int k = 0; k < 11; k++) begin
            wait_cyc(1);
            check_eq($sformatf("bounce_leds_%0d", k + 1), 32'(leds), 32'(bounce_exp[k]));
            check_eq($sformatf("bounce_step_%0d", k + 1), 32'(step_cnt), 32'(k + 1));
        end

        // Reload on a tick cycle: no shift applied on the reload edge
        pulse_cfg(32'h7, 32'h10, 32'd1);
        check_eq("collide_step", 32'(step_cnt), 32'd0);
        wait_cyc(1);
        check_eq("collide_leds", 32'(leds), 32'h10);
        check_eq("collide_step_next", 32'(step_cnt), 32'd1);

        // Blink, period 2
        pulse_cfg(32'h3, 32'h05, 32'd2);
        wait_cyc(1);
        check_eq("blink_n1", 32'(leds), 32'h05);
        wait_cyc(1);
        check_eq("blink_n2", 32'(leds), 32'h05);
        wait_cyc(1);
        check_eq("blink_n3", 32'(leds), 32'h00);
        wait_cyc(2);
        check_eq("blink_n5", 32'(leds), 32'h05);
        check_eq("blink_step", 32'(step_cnt), 32'd2);

        // Disabled after reload: dark and no steps
        pulse_cfg(32'h6, 32'h01, 32'd1);
        wait_cyc(5);
        check_eq("dis_leds", 32'(leds), 32'h0);
        check_eq("dis_step", 32'(step_cnt), 32'd0);

        // All-zero pattern stays dark in rotate
        pulse_cfg(32'h5, 32'h00, 32'd1);
        wait_cyc(10);
        check_eq("zero_leds", 32'(leds), 32'h0);
        check_eq("zero_step", 32'(step_cnt), 32'd10);

        // Asynchronous reset mid-operation
        pulse_cfg(32'h1, 32'hFF, 32'd2);
        wait_cyc(4);
        ARESETN = 1'b0;
        #1;
        check_eq("midrst_leds", 32'(leds), 32'h0);
        check_eq("midrst_step", 32'(step_cnt), 32'h0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        wait_cyc(1);
        check_eq("postrst_step_n1", 32'(step_cnt), 32'd0);
        wait_cyc(1);
        check_eq("postrst_step_n2", 32'(step_cnt), 32'd1);
        check_eq("postrst_leds", 32'(leds), 32'h0);

`ifdef EVEN_LEDS_PWM_EN
        duty_reg = 32'd64;
        pulse_cfg(32'h1, 32'h55, 32'd1);
        wait_cyc(2);
        pwm_count(on_cnt, bad_cnt);
        check_eq("pwm64_on", 32'(on_cnt), 32'd64);
        check_eq("pwm64_bad", 32'(bad_cnt), 32'd0);
        duty_reg = 32'd0;
        wait_cyc(2);
        pwm_count(on_cnt, bad_cnt);
        check_eq("pwm0_on", 32'(on_cnt), 32'd0);
        duty_reg = 32'hFF;
        wait_cyc(2);
        pwm_count(on_cnt, bad_cnt);
        check_eq("pwm255_on", 32'(on_cnt), 32'd256);
`else
        on_cnt  = 0;
        bad_cnt = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
